// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-state/FSM types and constants for the USB receive front end.
package usb_rx_pkg;

    // Encoding is {dp, dm} so a raw line sample casts directly to line_e
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_EOP,
        ST_ERROR
    } state_e;

    // LSB is the first bit on the wire: seven 0s then a 1
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
    localparam logic [2:0] MAX_ONES     = 3'd6;

endpackage

// File: rtl/nrzi_decoder.sv
// nrzi_decoder: classifies the dp/dm line and NRZI-decodes it against the last J/K sample.
//   clk, rst     : clock, async active-high reset
//   bit_en       : sample strobe; the previous-line register only moves on strobed J/K samples
//   dp, dm       : bus line
//   line         : current line classification (combinational)
//   dec_bit      : 1 when the line equals the previous J/K sample, 0 on a transition
module nrzi_decoder
    import usb_rx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  bit_en,
    input  logic  dp,
    input  logic  dm,
    output line_e line,
    output logic  dec_bit
);

    line_e prev_q, prev_d;

    always_comb begin
        line    = line_e'({dp, dm});
        dec_bit = (line == prev_q);
        // SE0/SE1 carry no NRZI information, so they leave the reference untouched
        prev_d  = (bit_en && (line == LINE_J || line == LINE_K)) ? line : prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= LINE_J;
        else     prev_q <= prev_d;
    end

endmodule

// File: rtl/rx_sync_decoder.sv
// rx_sync_decoder: USB receive front end - NRZI decode, SYNC detect, bit unstuffing, EOP/error tracking.
//   clk, rst      : clock, async active-high reset
//   bit_en        : bit-time strobe; nothing advances and no pulse is produced when low
//   dp, dm        : bus line
//   s_in          : decoded, unstuffed bit (registered, one cycle after its sample)
//   bit_valid     : s_in carries a payload bit
//   start_decode  : pulse with the first PID bit
//   end_PID       : pulse on packet end (EOP or recovery from error)
//   stuff_err     : pulse on a bit-stuff violation
//   rx_active     : high from SYNC match through the end_PID cycle
module rx_sync_decoder
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic dp,
    input  logic dm,
    output logic s_in,
    output logic bit_valid,
    output logic start_decode,
    output logic end_PID,
    output logic stuff_err,
    output logic rx_active
);

    line_e  line;
    logic   dec_bit;
    state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] fill_q, fill_d, ones_q, ones_d, pid_cnt_q, pid_cnt_d;
    logic se0_seen_q, se0_seen_d;
    logic s_in_q, s_in_d, bit_valid_q, bit_valid_d, start_q, start_d;
    logic end_pid_q, end_pid_d, stuff_err_q, stuff_err_d, rx_active_q, rx_active_d;
    logic is_jk, sync_hit;
    logic [7:0] shift_in;
    logic unused_shift_lsb;

    nrzi_decoder u_nrzi (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .dp      (dp),
        .dm      (dm),
        .line    (line),
        .dec_bit (dec_bit)
    );

    assign is_jk    = (line == LINE_J) || (line == LINE_K);
    assign shift_in = {dec_bit, shift_q[7:1]};
    // The cleared register is all zeros, so a match also needs 7 real bits already shifted in
    assign sync_hit = is_jk && (fill_q == 3'd7) && (shift_in == SYNC_PATTERN);
    assign unused_shift_lsb = shift_q[0];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        ones_d      = ones_q;
        pid_cnt_d   = pid_cnt_q;
        se0_seen_d  = se0_seen_q;
        s_in_d      = s_in_q;
        bit_valid_d = 1'b0;
        start_d     = 1'b0;
        end_pid_d   = 1'b0;
        stuff_err_d = 1'b0;
        if (bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_jk) begin
                        shift_d = shift_in;
                        fill_d  = (fill_q == 3'd7) ? fill_q : fill_q + 3'd1;
                        if (sync_hit) begin
                            state_d   = ST_PID;
                            ones_d    = 3'd1;
                            pid_cnt_d = 3'd0;
                        end
                    end
                end
                ST_PID, ST_DATA: begin
                    if (line == LINE_SE1) begin
                        state_d    = ST_ERROR;
                        se0_seen_d = 1'b0;
                    end else if (line == LINE_SE0) begin
                        state_d    = ST_EOP;
                        se0_seen_d = 1'b0;
                    end else if (ones_q == MAX_ONES) begin
                        // After six 1s the next bit must be a stuffed 0
                        if (dec_bit) begin
                            stuff_err_d = 1'b1;
                            state_d     = ST_ERROR;
                            se0_seen_d  = 1'b0;
                        end else begin
                            ones_d = 3'd0;
                        end
                    end else begin
                        s_in_d      = dec_bit;
                        bit_valid_d = 1'b1;
                        ones_d      = dec_bit ? ones_q + 3'd1 : 3'd0;
                        if (state_q == ST_PID) begin
                            start_d   = (pid_cnt_q == 3'd0);
                            pid_cnt_d = pid_cnt_q + 3'd1;
                            state_d   = (pid_cnt_q == 3'd7) ? ST_DATA : ST_PID;
                        end
                    end
                end
                ST_EOP: begin
                    if (!se0_seen_q && line == LINE_SE0) begin
                        se0_seen_d = 1'b1;
                    end else if (se0_seen_q && line == LINE_J) begin
                        end_pid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d    = ST_ERROR;
                        se0_seen_d = (line == LINE_SE0);
                    end
                end
                ST_ERROR: begin
                    if (se0_seen_q && line == LINE_J) begin
                        end_pid_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        se0_seen_d = (line == LINE_SE0);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_IDLE && state_q != ST_IDLE) begin
                shift_d = '0;
                fill_d  = '0;
                ones_d  = '0;
            end
        end
        rx_active_d = (state_d != ST_IDLE) || end_pid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            fill_q      <= '0;
            ones_q      <= '0;
            pid_cnt_q   <= '0;
            se0_seen_q  <= 1'b0;
            s_in_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            start_q     <= 1'b0;
            end_pid_q   <= 1'b0;
            stuff_err_q <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            ones_q      <= ones_d;
            pid_cnt_q   <= pid_cnt_d;
            se0_seen_q  <= se0_seen_d;
            s_in_q      <= s_in_d;
            bit_valid_q <= bit_valid_d;
            start_q     <= start_d;
            end_pid_q   <= end_pid_d;
            stuff_err_q <= stuff_err_d;
            rx_active_q <= rx_active_d;
        end
    end

    assign s_in         = s_in_q;
    assign bit_valid    = bit_valid_q;
    assign start_decode = start_q;
    assign end_PID      = end_pid_q;
    assign stuff_err    = stuff_err_q;
    assign rx_active    = rx_active_q;

endmodule

// File: tb/tb_rx_sync_decoder.sv
// tb_rx_sync_decoder: directed self-checking bench for rx_sync_decoder.
module tb_rx_sync_decoder;

    localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

    logic clk = 1'b0, rst = 1'b1, bit_en = 1'b1, dp = 1'b1, dm = 1'b0;
    logic s_in, bit_valid, start_decode, end_PID, stuff_err, rx_active;

    int n_chk = 0, n_pass = 0;
    int nv, n_sd, n_end, n_se, sd_idx;
    logic rx_seen;
    logic [63:0] bits;
    logic [1:0] cur = J;

    rx_sync_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .bit_en       (bit_en),
        .dp           (dp),
        .dm           (dm),
        .s_in         (s_in),
        .bit_valid    (bit_valid),
        .start_decode (start_decode),
        .end_PID      (end_PID),
        .stuff_err    (stuff_err),
        .rx_active    (rx_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        nv = 0; n_sd = 0; n_end = 0; n_se = 0; sd_idx = -1; bits = '0; rx_seen = 1'b0;
    endtask

    task automatic sym(input logic [1:0] l);
        {dp, dm} = l;
        if (l == J || l == K) cur = l;
        @(posedge clk);
        #1;
        if (start_decode) begin n_sd++; sd_idx = nv; end
        if (bit_valid) begin bits[nv] = s_in; nv++; end
        if (end_PID) n_end++;
        if (stuff_err) n_se++;
        if (rx_active) rx_seen = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        sym(b ? cur : (cur == J ? K : J));
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, s_in, bit_valid, start_decode, end_PID, stuff_err, rx_active}, 32'd0);
        rst = 1'b0;

        // ACK packet with a bit_en gap in the middle of the PID
        repeat (4) sym(J);
        chk("idle_rx_active", rx_active, 1'b0);
        send_sync();
        chk("sync_rx_active", rx_active, 1'b1);
        chk("sync_no_valid", bit_valid, 1'b0);
        clr();
        send_bit(1'b0);
        chk("ack_first_start", {start_decode, bit_valid, s_in}, 3'b110);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        bit_en = 1'b0; {dp, dm} = SE1;
        @(posedge clk); #1;
        chk("gap_no_pulses", {bit_valid, start_decode, end_PID, stuff_err}, 4'b0000);
        chk("gap_rx_active", rx_active, 1'b1);
        bit_en = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        sym(SE0);
        chk("eop_se0_no_valid", bit_valid, 1'b0);
        sym(SE0);
        sym(J);
        chk("ack_end_pulse", {end_PID, rx_active}, 2'b11);
        sym(J);
        chk("ack_after_end", {end_PID, rx_active}, 2'b00);
        chk("ack_nbits", nv, 8);
        chk("ack_pid", bits[7:0], 8'hD2);
        chk("ack_start_once", {n_sd[7:0], sd_idx[7:0]}, 16'h0100);
        chk("ack_end_once", n_end, 1);

        // Five payload 1s after SYNC, then a stuffed 0
        repeat (3) sym(J);
        send_sync();
        clr();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        chk("stuff_dropped", bit_valid, 1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        sym(SE0); sym(SE0); sym(J); sym(J);
        chk("stuff_nbits", nv, 10);
        chk("stuff_pid", bits[7:0], 8'hDF);
        chk("stuff_data", bits[9:8], 2'b01);
        chk("stuff_no_err", n_se, 0);
        chk("stuff_end", n_end, 1);

        // Six 1s in a row (counting the SYNC's) followed by a 1
        repeat (3) sym(J);
        send_sync();
        clr();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b1);
        chk("violation_pulse", {stuff_err, bit_valid}, 2'b10);
        send_bit(1'b0); send_bit(1'b1);
        chk("violation_one_pulse", stuff_err, 1'b0);
        sym(SE0); sym(J);
        chk("violation_end", end_PID, 1'b1);
        sym(J);
        chk("violation_idle", rx_active, 1'b0);
        chk("violation_nbits", nv, 5);
        chk("violation_nerr", n_se, 1);

        // Packet truncated after 3 PID bits
        repeat (3) sym(J);
        send_sync();
        clr();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        sym(SE0);
        chk("trunc_se0_no_valid", bit_valid, 1'b0);
        sym(SE0); sym(J);
        chk("trunc_end", end_PID, 1'b1);
        sym(J);
        chk("trunc_nbits", nv, 3);
        chk("trunc_bits", bits[2:0], 3'b010);
        chk("trunc_end_once", n_end, 1);

        // Incomplete SYNC followed by idle J must not start a packet
        repeat (3) sym(J);
        clr();
        sym(K); sym(J); sym(K); sym(J); sym(K); sym(J);
        repeat (10) sym(J);
        chk("short_sync_no_start", n_sd, 0);
        chk("short_sync_no_active", rx_seen, 1'b0);

        // Reset in the middle of the data phase, then a clean packet
        send_sync();
        send_byte(8'hD2);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("pre_reset_active", rx_active, 1'b1);
        rst = 1'b1;
        #2;
        chk("async_reset_outputs", {26'd0, s_in, bit_valid, start_decode, end_PID, stuff_err, rx_active}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr();
        cur = J;
        repeat (3) sym(J);
        chk("reset_no_end", n_end, 0);
        send_sync();
        send_byte(8'h5A);
        sym(SE0); sym(SE0); sym(J); sym(J);
        chk("post_reset_nbits", nv, 8);
        chk("post_reset_pid", bits[7:0], 8'h5A);
        chk("post_reset_start", n_sd, 1);
        chk("post_reset_end", n_end, 1);
        chk("post_reset_idle", rx_active, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
